bcd_stopwatch_ctrl: RTL and testbench
=====================================

Name: bcd_stopwatch_ctrl

Overview:
- Sequences a chain of cascaded BCD decade digits as a start/stop/lap stopwatch.
- Generates the count-enable tick from a clock prescaler and ripples carries between digits.
- Latches lap snapshots, halts and flags overflow at all-nines.
- Sits between front-panel control pulses and the 7-segment display mux.

Parameters:
- DIGITS, 4, number of cascaded BCD digits; digit 0 is least significant.
- TICK_DIV, 10, clk cycles per count increment; must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begin or resume counting.
- stop  input  1  single-cycle pulse; pause counting.
- clear  input  1  single-cycle pulse; return to zero and IDLE.
- lap  input  1  single-cycle pulse; snapshot count into lap_count.
- count  output  4*DIGITS  live BCD value; digit i is bits [4i+3:4i].
- lap_count  output  4*DIGITS  last lapped BCD value.
- running  output  1  high while in RUN.
- overflow  output  1  sticky; set on all-nines plus tick.
- tick  output  1  one-cycle pulse when an increment is applied.

Behaviour:
- Reset is synchronous and active-high: rst high at a posedge is sampled on that edge. It sets state IDLE and prescaler 0. count, lap_count, running, overflow and tick all reset to 0. Reset mid-count behaves identically.
- State register with states IDLE, RUN, PAUSED and OVF. Command priority in one cycle: clear > stop > start.
  - IDLE: start -> RUN. stop is ignored. count holds 0.
  - RUN: stop -> PAUSED. clear -> IDLE. An overflowing tick -> OVF.
  - PAUSED: start -> RUN. clear -> IDLE. count and prescaler are frozen, so resume keeps the partial period.
  - OVF: only clear (or rst) exits, to IDLE. start, stop and lap are ignored.
- running is registered and equals (state == RUN). It goes high the cycle after start is sampled.
- Prescaler advances only in RUN. It counts 0..TICK_DIV-1 and wraps to 0. tick is asserted for the cycle in which prescaler == TICK_DIV-1 and state is RUN.
- The first tick occurs TICK_DIV cycles after the start edge from IDLE. count updates on the same edge that ends the tick cycle.
- Digit cascade:
  - enable(0) = tick.
  - enable(i+1) = enable(i) AND digit(i) == 9.
  - An enabled digit at 9 goes to 0; otherwise it increments by 1. Digits never hold A–F.
- Overflow: when tick arrives with all digits at 9, count is held at all-nines rather than wrapping. overflow is set (sticky) and state goes to OVF on that edge.
- clear coincident with tick: clear wins. Count goes to 0 and no increment is applied.
- stop coincident with tick: the increment is applied on that edge, then state becomes PAUSED.
- lap is honoured in RUN and PAUSED. lap_count takes the pre-increment value of count on that edge. lap in IDLE or OVF is ignored.
- clear resets count, lap_count, overflow and the prescaler.

Decomposition:
- Shared package bcd_pkg holds:
  - a typedef for a 4-bit BCD digit;
  - the constant BCD_MAX = 4'd9;
  - the state enum {IDLE, RUN, PAUSED, OVF}.
- Natural sub-module: bcd_decade_digit. It has clk, rst, clr, en, a 4-bit q, and a terminal output (q == 9). It is instantiated DIGITS times with a generate loop.
- The prescaler and FSM stay in the top level.

Test Plan:
- Reset and start: DIGITS=4, TICK_DIV=2; rst, then start. running=1 the next cycle; first tick 2 cycles after start; count=0x0001 after the tick edge.
- Carry ripple: run to 0x0099, then 1 tick -> count=0x0100. One further tick -> 0x0101. No A–F value is ever observed.
- Pause and resume: stop at mid-prescaler -> count frozen and tick silent for 20 cycles. start -> next tick arrives after the remaining prescaler cycles only.
- Lap: lap at count=0x0042 coincident with tick -> lap_count=0x0042 and count=0x0043. lap in IDLE leaves lap_count unchanged.
- Overflow: run to 0x9999, then tick -> count stays 0x9999, overflow=1, running=0. start is ignored. clear -> count=0, overflow=0, IDLE.
- Priority and reset: clear and start in the same cycle while in RUN -> IDLE with count=0. rst asserted mid-RUN -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD stopwatch controller and its digit cells.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    OVF
  } sw_state_t;

endpackage

// File: rtl/bcd_decade_digit.sv
// One BCD decade: counts 0..9 when enabled, wraps to 0, and flags terminal value 9.
module bcd_decade_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       terminal
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == BCD_MAX) ? '0 : q + 4'd1;
    end
  end

  always_comb begin
    terminal = (q == BCD_MAX);
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/lap stopwatch: prescaled tick drives a cascade of BCD digits,
// with lap snapshot and sticky overflow that halts at all-nines.
module bcd_stopwatch_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   lap_count,
  output logic                  running,
  output logic                  overflow,
  output logic                  tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  sw_state_t       state;
  sw_state_t       state_nxt;
  logic [PW-1:0]   presc;
  logic [DIGITS-1:0] dig_en;
  logic [DIGITS-1:0] dig_term;
  logic            all_nines;
  logic            inc;
  logic            ovf_hit;
  logic            lap_take;
  logic            presc_adv;

  // State register plus registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      running  <= 1'b0;
    end else begin
      state    <= state_nxt;
      running  <= (state_nxt == RUN);
    end
  end

  // Next-state logic; clear beats stop beats start, overflow beats stop.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!clear && !stop && start) state_nxt = RUN;
      end
      RUN: begin
        if (clear)        state_nxt = IDLE;
        else if (ovf_hit) state_nxt = OVF;
        else if (stop)    state_nxt = PAUSED;
      end
      PAUSED: begin
        if (clear)              state_nxt = IDLE;
        else if (!stop && start) state_nxt = RUN;
      end
      OVF: begin
        if (clear) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output/control decode for the current cycle.
  always_comb begin
    tick      = 1'b0;
    all_nines = &dig_term;
    ovf_hit   = 1'b0;
    inc       = 1'b0;
    lap_take  = 1'b0;
    presc_adv = 1'b0;
    if (state == RUN && !clear) begin
      presc_adv = 1'b1;
      tick      = (presc == PRESC_LAST);
    end
    ovf_hit  = tick && all_nines;
    inc      = tick && !all_nines;
    lap_take = lap && !clear && ((state == RUN) || (state == PAUSED));
  end

  // Prescaler freezes outside RUN so a resume continues the partial period.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc <= '0;
    end else if (presc_adv) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      overflow  <= 1'b0;
      lap_count <= '0;
    end else begin
      if (ovf_hit)  overflow  <= 1'b1;
      if (lap_take) lap_count <= count;
    end
  end

  // Carry ripple: a digit advances only when every lower digit is at 9.
  always_comb begin
    dig_en    = '0;
    dig_en[0] = inc;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      dig_en[i] = dig_en[i-1] & dig_term[i-1];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_decade_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr      (clear),
      .en       (dig_en[g]),
      .q        (count[4*g+3:4*g]),
      .terminal (dig_term[g])
    );
  end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Randomised and directed bench for bcd_stopwatch_ctrl against an integer-count reference model.
module tb_bcd_stopwatch_ctrl;

  localparam int DIGITS = 4;
  localparam int TD     = 2;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_OVF   = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clear = 1'b0;
  logic         lap = 1'b0;
  logic [W-1:0] count;
  logic [W-1:0] lap_count;
  logic         running;
  logic         overflow;
  logic         tick;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .lap       (lap),
    .count     (count),
    .lap_count (lap_count),
    .running   (running),
    .overflow  (overflow),
    .tick      (tick)
  );

  int n_checks = 0;
  int n_err    = 0;

  int m_count, m_lap, m_presc, m_mode;
  bit m_ovf;
  bit m_valid = 1'b0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check tick mid-cycle, advance model, check registered outputs.
  task automatic cyc(input bit s, input bit sp, input bit cl, input bit lp, input bit r);
    bit t;
    @(negedge clk);
    start = s; stop = sp; clear = cl; lap = lp; rst = r;
    #1;
    t = m_valid && (m_mode == M_RUN) && (m_presc == TD - 1) && !cl;
    if (m_valid) chk("tick", 32'(tick), 32'(t));
    @(posedge clk);
    if (r) begin
      m_count = 0; m_lap = 0; m_presc = 0; m_mode = M_IDLE; m_ovf = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (cl) begin
        m_count = 0; m_lap = 0; m_presc = 0; m_mode = M_IDLE; m_ovf = 1'b0;
      end else begin
        if (lp && (m_mode == M_RUN || m_mode == M_PAUSE)) m_lap = m_count;
        if (m_mode == M_RUN) m_presc = (m_presc + 1) % TD;
        if (t) begin
          if (m_count == MAXV) begin
            m_ovf = 1'b1; m_mode = M_OVF;
          end else begin
            m_count++;
            if (sp) m_mode = M_PAUSE;
          end
        end else begin
          case (m_mode)
            M_IDLE:  if (s && !sp) m_mode = M_RUN;
            M_RUN:   if (sp) m_mode = M_PAUSE;
            M_PAUSE: if (s && !sp) m_mode = M_RUN;
            default: ;
          endcase
        end
      end
    end
    #1;
    if (m_valid) begin
      chk("count", 32'(count), 32'(to_bcd(m_count)));
      chk("lap_count", 32'(lap_count), 32'(to_bcd(m_lap)));
      chk("running", 32'(running), 32'(m_mode == M_RUN));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic run_until(input int target, input int budget);
    while (m_count != target && budget > 0) begin
      cyc(0, 0, 0, 0, 0);
      budget--;
    end
    chk("reach_target", 32'(m_count), 32'(target));
  endtask

  int saved;
  int budget;

  initial begin
    // Reset and start
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_running", 32'(running), 32'h0);
    cyc(1, 0, 0, 0, 0);
    chk("start_running", 32'(running), 32'h1);
    idle(2);
    chk("first_tick_count", 32'(count), 32'h0001);

    // Carry ripple
    run_until(99, 400);
    run_until(100, 10);
    chk("carry_0100", 32'(count), 32'h0100);
    run_until(101, 10);
    chk("carry_0101", 32'(count), 32'h0101);

    // Pause mid-period and resume
    budget = 10;
    while (m_presc != 0 && budget > 0) begin cyc(0, 0, 0, 0, 0); budget--; end
    cyc(0, 1, 0, 0, 0);
    saved = m_count;
    idle(20);
    chk("pause_frozen", 32'(count), 32'(to_bcd(saved)));
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("resume_partial", 32'(count), 32'(to_bcd(saved + 1)));

    // Lap coincident with tick
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    run_until(42, 200);
    budget = 10;
    while (m_presc != TD - 1 && budget > 0) begin cyc(0, 0, 0, 0, 0); budget--; end
    cyc(0, 0, 0, 1, 0);
    chk("lap_value", 32'(lap_count), 32'h0042);
    chk("lap_count_next", 32'(count), 32'h0043);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("lap_idle_ignored", 32'(lap_count), 32'h0);

    // Overflow
    cyc(1, 0, 0, 0, 0);
    run_until(7, 50);
    cyc(0, 0, 0, 1, 0);
    saved = m_lap;
    budget = 25000;
    while (!m_ovf && budget > 0) begin cyc(0, 0, 0, 0, 0); budget--; end
    chk("ovf_count", 32'(count), 32'h9999);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_running", 32'(running), 32'h0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    idle(4);
    chk("ovf_start_ignored", 32'(count), 32'h9999);
    chk("ovf_lap_ignored", 32'(lap_count), 32'(to_bcd(saved)));
    chk("ovf_still_stopped", 32'(running), 32'h0);
    cyc(0, 0, 1, 0, 0);
    chk("clear_count", 32'(count), 32'h0);
    chk("clear_overflow", 32'(overflow), 32'h0);

    // Priority and reset mid-run
    cyc(1, 0, 0, 0, 0);
    idle(7);
    cyc(1, 0, 1, 0, 0);
    chk("clear_beats_start_count", 32'(count), 32'h0);
    chk("clear_beats_start_run", 32'(running), 32'h0);
    cyc(1, 0, 0, 0, 0);
    idle(9);
    cyc(0, 0, 0, 1, 0);
    idle(3);
    cyc(0, 0, 0, 0, 1);
    chk("rst_mid_count", 32'(count), 32'h0);
    chk("rst_mid_lap", 32'(lap_count), 32'h0);
    chk("rst_mid_running", 32'(running), 32'h0);
    chk("rst_mid_tick", 32'(tick), 32'h0);

    // Random command traffic
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 499) == 0);
    end

    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0; rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
